// File: rtl/bin2bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
// Holds the FSM state encoding and a digit-count sizing function.
package bin2bcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   // Decimal digits needed to hold 2^bin_w-1 without overflow.
   function automatic int min_digits(input int bin_w);
      longint unsigned lim;
      longint unsigned p;
      int d;
      lim = (64'd1 << bin_w) - 64'd1;
      p = 64'd10;
      d = 1;
      for (int i = 0; i < 20; i++) begin
         if (p <= lim) begin
            d = d + 1;
            p = p * 64'd10;
         end
      end
      return d;
   endfunction

endpackage

// File: rtl/bin2bcd_seq_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more
// so the following left shift carries correctly into the next digit.
module bcd_digit_adj (
   input  logic [3:0] d_i,
   output logic [3:0] d_o
);

   assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary to BCD converter, one bit per cycle.
// Overflow is sticky when a bit falls off the top digit.
module bin2bcd_seq
   import bin2bcd_pkg::*;
#(
   parameter int BIN_W  = 16,
   parameter int DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin,
   output logic                  busy,
   output logic                  valid,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  ovf
);

   localparam int CW = $clog2(BIN_W + 1);
   localparam int DW = 4 * DIGITS;

   state_e           state_q, state_d;
   logic [BIN_W-1:0] sr_q, sr_d;
   logic [DW-1:0]    dig_q, dig_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             flag_q, flag_d;
   logic [DW-1:0]    bcd_q, bcd_d;
   logic             ovf_q, ovf_d;
   logic             valid_q, valid_d;
   logic [DW-1:0]    adj;

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .d_i(dig_q[4*g +: 4]),
         .d_o(adj[4*g +: 4])
      );
   end

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      dig_d   = dig_q;
      cnt_d   = cnt_q;
      flag_d  = flag_q;
      bcd_d   = bcd_q;
      ovf_d   = ovf_q;
      valid_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               sr_d    = bin;
               dig_d   = '0;
               flag_d  = 1'b0;
               cnt_d   = CW'(BIN_W);
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            {dig_d, sr_d} = {adj[DW-2:0], sr_q, 1'b0};
            flag_d = flag_q | adj[DW-1];
            cnt_d  = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            bcd_d   = dig_q;
            ovf_d   = flag_q;
            valid_d = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sr_q    <= '0;
         dig_q   <= '0;
         cnt_q   <= '0;
         flag_q  <= 1'b0;
         bcd_q   <= '0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         dig_q   <= dig_d;
         cnt_q   <= cnt_d;
         flag_q  <= flag_d;
         bcd_q   <= bcd_d;
         ovf_q   <= ovf_d;
         valid_q <= valid_d;
      end
   end

   assign busy  = (state_q != IDLE);
   assign valid = valid_q;
   assign bcd   = bcd_q;
   assign ovf   = ovf_q;

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter BIN_W, default 16: width of the unsigned binary input, legal range 4..32.
REQ-002 Parameter DIGITS, default 5: number of BCD output digits, legal range 1..10.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 Port start, input, 1: request to convert the value on bin; sampled only when busy=0.
REQ-006 Port bin, input, BIN_W: unsigned binary operand, captured in the cycle start is accepted.
REQ-007 Port busy, output, 1: high while a conversion is in progress; start is ignored while high.
REQ-008 Port valid, output, 1: one-cycle pulse marking bcd and ovf as updated.
REQ-009 Port bcd, output, 4*DIGITS: packed BCD result, digit 0 in bits [3:0]; held until the next valid.
REQ-010 Port ovf, output, 1: high when the operand exceeded 10^DIGITS-1; held with bcd.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-012 In IDLE with start=1, the block SHALL latch bin into a BIN_W shift register, clear the digit register and the overflow flag, load the iteration counter with BIN_W, and enter SHIFT.
REQ-013 Each SHIFT cycle SHALL first add 3 to every digit whose value is >=5, then shift {digits, shift register} left by one, with the shift register MSB entering digit 0 bit 0.
REQ-014 The bit shifted out of the top digit's MSB in any SHIFT cycle SHALL set the overflow flag (sticky for this conversion).
REQ-015 The block SHALL stay in SHIFT for exactly BIN_W cycles, then enter DONE.
REQ-016 In DONE the block SHALL drive bcd from the digit register, drive ovf from the overflow flag, assert valid for one cycle, and return to IDLE.
REQ-017 Latency SHALL be BIN_W+1 cycles from the start-accept edge to the valid-high cycle; throughput SHALL be one conversion per BIN_W+2 cycles.
REQ-018 busy SHALL be 1 in SHIFT and DONE and 0 in IDLE; start=1 while busy=1 SHALL have no effect and SHALL not be queued.
REQ-019 bin changes after the accept edge SHALL NOT affect the result in progress.
REQ-020 When ovf=1, bcd SHALL hold the operand modulo 10^DIGITS (lower digits correct).
REQ-021 Every digit of bcd SHALL be in 0..9 for any input.

Reset
REQ-022 While rst_n=0 at a clock edge: state SHALL become IDLE; busy, valid and ovf SHALL become 0; bcd SHALL become all-zero; the counter and shift register SHALL be cleared.
REQ-023 Reset asserted mid-conversion SHALL abort the conversion with no valid pulse; the first start after rst_n returns high SHALL be accepted normally.

Structure
REQ-024 Shared package bin2bcd_pkg SHALL hold the state type (IDLE/SHIFT/DONE) and a constant function returning the minimum DIGITS required for a given BIN_W.
REQ-025 The per-digit add-3 correction SHALL be a combinational sub-module bcd_digit_adj (4-bit in, 4-bit out), instantiated DIGITS times via generate.
REQ-026 The counter width SHALL be clog2(BIN_W+1) bits.

Verification
REQ-027 BIN_W=16, DIGITS=5, bin=65535 with start -> valid exactly 17 cycles later, bcd=0x65535, ovf=0.
REQ-028 BIN_W=16, DIGITS=5, bin=0 -> bcd=0x00000, ovf=0; then bin=9 -> bcd=0x00009.
REQ-029 BIN_W=16, DIGITS=4, bin=12345 -> bcd=0x2345, ovf=1; then bin=9999 -> bcd=0x9999, ovf=0.
REQ-030 Start held high continuously with bin changing each cycle -> conversions accepted only on busy=0 cycles (every 18 cycles); each result matches the bin value at its accept edge.
REQ-031 rst_n=0 for one cycle, 5 cycles into a conversion -> no valid, busy=0 and bcd=0 next cycle; a following start with bin=42 -> bcd=0x00042.
REQ-032 Random sweep of 10k operands (BIN_W=16, DIGITS=5) against a decimal reference model -> all digits match, ovf=0 throughout.
